data_mem_responder: RTL and testbench

- Responder end of the memory-access-stage interface: services the stage's combinational address, data and write-enable outputs, and returns read data within the same cycle.
- Backed by a word-addressed RAM region plus a small memory-mapped I/O (MMIO) block: GPIO, cycle counter with snapshot, and a sticky error status.
- Sits beside the pipeline at top level, between the memory stage and board I/O.

---
 rtl/data_mem_pkg.sv | 23 ++
 rtl/data_mem_cycle_counter.sv | 25 ++
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants and types for the data-memory responder: MMIO offsets,
// CYC_CTRL bit positions and the address-region decode enum.
package data_mem_pkg;

  localparam logic [2:0] GPIO_OUT_OFS    = 3'd0;
  localparam logic [2:0] GPIO_IN_OFS     = 3'd1;
  localparam logic [2:0] CYC_CTRL_OFS    = 3'd2;
  localparam logic [2:0] CYC_SNAP_LO_OFS = 3'd3;
  localparam logic [2:0] CYC_SNAP_HI_OFS = 3'd4;
  localparam logic [2:0] ERR_STATUS_OFS  = 3'd5;

  localparam int unsigned MMIO_WORDS = 6;

  localparam int unsigned SNAP_BIT = 0;
  localparam int unsigned CLR_BIT  = 1;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_UNMAPPED
  } region_t;

endpackage

// File: rtl/data_mem_cycle_counter.sv
// Free-running 32-bit cycle counter with a snapshot register; a snapshot
// taken together with a clear captures the pre-clear count.
module cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        snap_req,
  input  logic        clr_req,
  output logic [31:0] snap
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      snap  <= '0;
    end else begin
      if (snap_req) begin
        snap <= count;
      end
      count <= clr_req ? '0 : count + 32'd1;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: word RAM plus GPIO / cycle-counter / error MMIO.
// Define DATA_MEM_CYCLE_COUNTER_EN to build the cycle counter and snapshot.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       RAM_DEPTH = 4096,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hFF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_to_memory,
  input  logic [DATA_W-1:0] data_to_memory,
  input  logic              data_to_memory_write_en,
  output logic [DATA_W-1:0] data_from_memory,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic              mem_err
);

  localparam int unsigned     RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_W:0] RAM_LIMIT = (ADDR_W+1)'(RAM_DEPTH);

  logic [DATA_W-1:0] ram [RAM_DEPTH];

  region_t           region;
  logic [ADDR_W-1:0] mmio_ofs_full;
  logic [2:0]        ofs;
  logic              wr_en;
  logic              wr_ram;
  logic              wr_gpio;
  logic              err_set;
  logic              err_clr;
  logic [DATA_W-1:0] gpio_sync1;
  logic [DATA_W-1:0] gpio_sync2;

`ifdef DATA_MEM_CYCLE_COUNTER_EN
  logic              wr_ctrl;
  logic [31:0]       snap;
`endif

  assign mmio_ofs_full = address_to_memory - MMIO_BASE;
  assign ofs           = mmio_ofs_full[2:0];
  assign wr_en         = data_to_memory_write_en && !rst;

  always_comb begin
    region = REGION_UNMAPPED;
    if ({1'b0, address_to_memory} < RAM_LIMIT) begin
      region = REGION_RAM;
    end else if (address_to_memory >= MMIO_BASE &&
                 mmio_ofs_full < ADDR_W'(MMIO_WORDS)) begin
      region = REGION_MMIO;
    end
  end

  // Write-side decode; read-only and unmapped targets raise mem_err instead.
  always_comb begin
    wr_ram  = 1'b0;
    wr_gpio = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
`ifdef DATA_MEM_CYCLE_COUNTER_EN
    wr_ctrl = 1'b0;
`endif
    if (wr_en) begin
      case (region)
        REGION_RAM: wr_ram = 1'b1;
        REGION_MMIO: begin
          case (ofs)
            GPIO_OUT_OFS: wr_gpio = 1'b1;
            GPIO_IN_OFS, CYC_SNAP_LO_OFS, CYC_SNAP_HI_OFS: err_set = 1'b1;
            CYC_CTRL_OFS: begin
`ifdef DATA_MEM_CYCLE_COUNTER_EN
              wr_ctrl = 1'b1;
`endif
            end
            ERR_STATUS_OFS: err_clr = data_to_memory[0];
            default: err_set = 1'b1;
          endcase
        end
        default: err_set = 1'b1;
      endcase
    end
  end

  // RAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[address_to_memory[RAM_AW-1:0]] <= data_to_memory;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
      mem_err    <= 1'b0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
      if (wr_gpio) begin
        gpio_out <= data_to_memory;
      end
      if (err_set) begin
        mem_err <= 1'b1;
      end else if (err_clr) begin
        mem_err <= 1'b0;
      end
    end
  end

`ifdef DATA_MEM_CYCLE_COUNTER_EN
  cycle_counter u_cycle_counter (
    .clk      (clk),
    .rst      (rst),
    .snap_req (wr_ctrl && data_to_memory[SNAP_BIT]),
    .clr_req  (wr_ctrl && data_to_memory[CLR_BIT]),
    .snap     (snap)
  );
`endif

  // Reads have no side effects; a same-cycle store is seen only next cycle.
  always_comb begin
    data_from_memory = '0;
    case (region)
      REGION_RAM: data_from_memory = ram[address_to_memory[RAM_AW-1:0]];
      REGION_MMIO: begin
        case (ofs)
          GPIO_OUT_OFS:    data_from_memory = gpio_out;
          GPIO_IN_OFS:     data_from_memory = gpio_sync2;
`ifdef DATA_MEM_CYCLE_COUNTER_EN
          CYC_SNAP_LO_OFS: data_from_memory = DATA_W'(snap[15:0]);
          CYC_SNAP_HI_OFS: data_from_memory = DATA_W'(snap[31:16]);
`endif
          ERR_STATUS_OFS:  data_from_memory[0] = mem_err;
          default:         data_from_memory = '0;
        endcase
      end
      default: data_from_memory = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, hand-written corner sequences
// and randomized traffic against a behavioural model of the memory map.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address_to_memory;
  logic [15:0] data_to_memory;
  logic        data_to_memory_write_en;
  logic [15:0] data_from_memory;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        mem_err;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .RAM_DEPTH (4096),
    .MMIO_BASE (16'hFF00)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .address_to_memory       (address_to_memory),
    .data_to_memory          (data_to_memory),
    .data_to_memory_write_en (data_to_memory_write_en),
    .data_from_memory        (data_from_memory),
    .gpio_in                 (gpio_in),
    .gpio_out                (gpio_out),
    .mem_err                 (mem_err)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the memory map
  logic [15:0] m_ram [int];
  logic [15:0] m_gpio;
  logic [15:0] m_sync [2];
  logic        m_err;
  logic [31:0] m_cyc;
  logic [31:0] m_snap;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        we;
    logic        chk_rd;
    logic [15:0] rd;
    logic [15:0] gpio;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_read(input logic [15:0] a, output logic [15:0] v);
    v = '0;
    if (a < 16'd4096) begin
      if (!m_ram.exists(int'(a))) return 1'b0;
      v = m_ram[int'(a)];
    end else if (a >= 16'hFF00 && a <= 16'hFF05) begin
      case (a - 16'hFF00)
        16'd0: v = m_gpio;
        16'd1: v = m_sync[0];
`ifdef DATA_MEM_CYCLE_COUNTER_EN
        16'd3: v = m_snap[15:0];
        16'd4: v = m_snap[31:16];
`endif
        16'd5: v = {15'd0, m_err};
        default: v = '0;
      endcase
    end
    return 1'b1;
  endfunction

  // Apply the effect of the upcoming posedge to the model.
  task automatic model_edge();
    logic [31:0] next_cyc;
    if (rst) begin
      m_gpio = '0;
      m_sync[0] = '0;
      m_sync[1] = '0;
      m_err = 1'b0;
      m_cyc = '0;
      m_snap = '0;
    end else begin
      next_cyc = m_cyc + 32'd1;
      m_sync[0] = m_sync[1];
      m_sync[1] = gpio_in;
      if (data_to_memory_write_en) begin
        if (address_to_memory < 16'd4096) begin
          m_ram[int'(address_to_memory)] = data_to_memory;
        end else if (address_to_memory >= 16'hFF00 && address_to_memory <= 16'hFF05) begin
          case (address_to_memory - 16'hFF00)
            16'd0: m_gpio = data_to_memory;
            16'd1, 16'd3, 16'd4: m_err = 1'b1;
            16'd2: begin
`ifdef DATA_MEM_CYCLE_COUNTER_EN
              if (data_to_memory[0]) m_snap = m_cyc;
              if (data_to_memory[1]) next_cyc = '0;
`endif
            end
            default: if (data_to_memory[0]) m_err = 1'b0;
          endcase
        end else begin
          m_err = 1'b1;
        end
      end
      m_cyc = next_cyc;
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w, input logic [15:0] g);
    address_to_memory = a;
    data_to_memory = d;
    data_to_memory_write_en = w;
    gpio_in = g;
    @(negedge clk);
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [15:0] v;
    if (model_read(address_to_memory, v)) begin
      check({tag, " rd"}, {16'd0, data_from_memory}, {16'd0, v});
    end
    check({tag, " gpio_out"}, {16'd0, gpio_out}, {16'd0, m_gpio});
    check({tag, " mem_err"}, {31'd0, mem_err}, {31'd0, m_err});
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] snap_lo;

    rst = 1'b1;
    address_to_memory = '0;
    data_to_memory = '0;
    data_to_memory_write_en = 1'b0;
    gpio_in = '0;
    @(posedge clk);
    #1;
    drive(16'h0000, 16'h0, 1'b0, 16'h0);
    advance();
    drive(16'h0000, 16'h0, 1'b0, 16'h0);
    advance();
    rst = 1'b0;

    // Reset state
    drive(16'hFF00, 16'h0, 1'b0, 16'h0);
    check("reset gpio_out", {16'd0, gpio_out}, 32'h0);
    check("reset mem_err", {31'd0, mem_err}, 32'h0);
    check("reset rd gpio", {16'd0, data_from_memory}, 32'h0);
    advance();

    //            addr      data      we    chk   rd        gpio      err
    tbl.push_back('{16'hFF00, 16'h00A5, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{16'hFF00, 16'h0000, 1'b0, 1'b1, 16'h00A5, 16'h00A5, 1'b0});
    tbl.push_back('{16'h0010, 16'h1111, 1'b1, 1'b0, 16'h0000, 16'h00A5, 1'b0});
    tbl.push_back('{16'h0010, 16'hBEEF, 1'b1, 1'b1, 16'h1111, 16'h00A5, 1'b0});
    tbl.push_back('{16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'h00A5, 1'b0});
    tbl.push_back('{16'h8000, 16'h5555, 1'b1, 1'b1, 16'h0000, 16'h00A5, 1'b0});
    tbl.push_back('{16'h8000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00A5, 1'b1});
    tbl.push_back('{16'hFF05, 16'h0000, 1'b1, 1'b1, 16'h0001, 16'h00A5, 1'b1});
    tbl.push_back('{16'hFF05, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h00A5, 1'b1});
    tbl.push_back('{16'hFF05, 16'h0001, 1'b1, 1'b1, 16'h0001, 16'h00A5, 1'b1});
    tbl.push_back('{16'hFF05, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00A5, 1'b0});
    tbl.push_back('{16'hFF03, 16'h1234, 1'b1, 1'b1, 16'h0000, 16'h00A5, 1'b0});
    tbl.push_back('{16'hFF05, 16'hFFFF, 1'b1, 1'b1, 16'h0001, 16'h00A5, 1'b1});
    tbl.push_back('{16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'h00A5, 1'b0});
    tbl.push_back('{16'hFF01, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 16'h00A5, 1'b0});
    tbl.push_back('{16'hFF05, 16'h0001, 1'b1, 1'b1, 16'h0001, 16'h00A5, 1'b1});
    tbl.push_back('{16'h0FFF, 16'h7E57, 1'b1, 1'b0, 16'h0000, 16'h00A5, 1'b0});
    tbl.push_back('{16'h0FFF, 16'h0000, 1'b0, 1'b1, 16'h7E57, 16'h00A5, 1'b0});
    tbl.push_back('{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0000, 16'h00A5, 1'b0});
    tbl.push_back('{16'h1000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00A5, 1'b1});
    tbl.push_back('{16'hFF05, 16'h0003, 1'b1, 1'b1, 16'h0001, 16'h00A5, 1'b1});
    tbl.push_back('{16'hFF06, 16'h0001, 1'b1, 1'b1, 16'h0000, 16'h00A5, 1'b0});
    tbl.push_back('{16'hFF05, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h00A5, 1'b1});
    tbl.push_back('{16'hFF04, 16'h0001, 1'b1, 1'b1, 16'h0000, 16'h00A5, 1'b1});
    tbl.push_back('{16'hFF05, 16'h0001, 1'b1, 1'b1, 16'h0001, 16'h00A5, 1'b1});
    tbl.push_back('{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00A5, 1'b0});
    tbl.push_back('{16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00A5, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].addr, tbl[i].data, tbl[i].we, 16'h0);
      if (tbl[i].chk_rd) begin
        check($sformatf("vec%0d rd", i), {16'd0, data_from_memory}, {16'd0, tbl[i].rd});
      end
      check($sformatf("vec%0d gpio_out", i), {16'd0, gpio_out}, {16'd0, tbl[i].gpio});
      check($sformatf("vec%0d mem_err", i), {31'd0, mem_err}, {31'd0, tbl[i].err});
      advance();
    end

    // GPIO input synchroniser latency
    for (int i = 0; i < 3; i++) begin
      drive(16'hFF01, 16'h0, 1'b0, 16'h1234);
      check($sformatf("gpio_in sync c%0d", i), {16'd0, data_from_memory},
            (i < 2) ? 32'h0 : 32'h1234);
      advance();
    end

`ifndef DATA_MEM_CYCLE_COUNTER_EN
    drive(16'hFF02, 16'h0003, 1'b1, 16'h1234);
    check("nocnt ctrl rd", {16'd0, data_from_memory}, 32'h0);
    advance();
    drive(16'hFF05, 16'h0, 1'b0, 16'h1234);
    check("nocnt ctrl no err", {31'd0, mem_err}, 32'h0);
    advance();
    drive(16'hFF03, 16'h0, 1'b0, 16'h1234);
    check("nocnt snap_lo rd", {16'd0, data_from_memory}, 32'h0);
    advance();
    drive(16'hFF04, 16'h0, 1'b0, 16'h1234);
    check("nocnt snap_hi rd", {16'd0, data_from_memory}, 32'h0);
    advance();
`endif

    // Reset drops same-cycle writes and clears registers
    drive(16'h8000, 16'h1, 1'b1, 16'h1234);
    advance();
    rst = 1'b1;
    drive(16'hFF00, 16'hFFFF, 1'b1, 16'h1234);
    check("pre-reset mem_err", {31'd0, mem_err}, 32'h1);
    advance();
    drive(16'h0010, 16'hDEAD, 1'b1, 16'h1234);
    advance();
    rst = 1'b0;
    drive(16'hFF01, 16'h0, 1'b0, 16'h1234);
    check("post-reset gpio_out", {16'd0, gpio_out}, 32'h0);
    check("post-reset mem_err", {31'd0, mem_err}, 32'h0);
    check("post-reset sync", {16'd0, data_from_memory}, 32'h0);
    advance();
    drive(16'h0010, 16'h0, 1'b0, 16'h1234);
    check("reset-cycle write dropped", {16'd0, data_from_memory}, 32'hBEEF);
    advance();

`ifdef DATA_MEM_CYCLE_COUNTER_EN
    for (int i = 0; i < 98; i++) begin
      drive(16'h0010, 16'h0, 1'b0, 16'h0);
      advance();
    end
    drive(16'hFF02, 16'h0001, 1'b1, 16'h0);
    advance();
    drive(16'hFF03, 16'h0, 1'b0, 16'h0);
    snap_lo = data_from_memory;
    check("snap ~100", {31'd0, (snap_lo >= 16'd99 && snap_lo <= 16'd101)}, 32'h1);
    check_model("snap lo");
    advance();
    drive(16'hFF04, 16'h0, 1'b0, 16'h0);
    check("snap hi zero", {16'd0, data_from_memory}, 32'h0);
    advance();
    drive(16'hFF02, 16'h0003, 1'b1, 16'h0);
    advance();
    drive(16'hFF03, 16'h0, 1'b0, 16'h0);
    check_model("snap preclear");
    check("snap preclear nonzero", {31'd0, (data_from_memory > snap_lo)}, 32'h1);
    advance();
    drive(16'hFF02, 16'h0003, 1'b1, 16'h0);
    advance();
    drive(16'hFF02, 16'h0001, 1'b1, 16'h0);
    advance();
    drive(16'hFF03, 16'h0, 1'b0, 16'h0);
    check("count zero after clear", {16'd0, data_from_memory}, 32'h0);
    advance();

    force dut.u_cycle_counter.count = 32'hFFFF_FFFE;
    release dut.u_cycle_counter.count;
    m_cyc = 32'hFFFF_FFFE;
    drive(16'hFF02, 16'h0001, 1'b1, 16'h0);
    advance();
    drive(16'hFF04, 16'h0, 1'b0, 16'h0);
    check("wrap snap hi before", {16'd0, data_from_memory}, 32'hFFFF);
    advance();
    drive(16'hFF02, 16'h0001, 1'b1, 16'h0);
    advance();
    drive(16'hFF04, 16'h0, 1'b0, 16'h0);
    check("wrap snap hi after", {16'd0, data_from_memory}, 32'h0);
    check_model("wrap");
    advance();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: a = 16'($urandom_range(0, 15));
        1: a = 16'h0FFF;
        2: a = 16'hFF00 + 16'($urandom_range(0, 7));
        3: a = 16'h1000 + 16'($urandom_range(0, 3));
        4: a = 16'hFFFF;
        default: a = 16'hFF05;
      endcase
      rst = ($urandom_range(0, 49) == 0);
      drive(a, 16'($urandom), ($urandom_range(0, 2) == 0), 16'($urandom));
      check_model($sformatf("rand%0d", i));
      advance();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
